// File: rtl/bp_pkg.sv
// Shared types and helpers for the fetch-side branch predictor.
package bp_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bp_ctr_t;

  localparam bp_ctr_t     CTR_RESET = WNT;
  localparam logic [31:0] STAT_MAX  = 32'hFFFF_FFFF;

  // 2-bit saturating counter step toward the observed outcome.
  function automatic bp_ctr_t ctr_next(bp_ctr_t c, logic taken);
    bp_ctr_t n;
    n = c;
    if (taken) begin
      case (c)
        SNT:     n = WNT;
        WNT:     n = WT;
        default: n = ST;
      endcase
    end else begin
      case (c)
        ST:      n = WT;
        WT:      n = WNT;
        default: n = SNT;
      endcase
    end
    return n;
  endfunction

endpackage

// File: rtl/bp_counter_table.sv
// Direction counter table: async-reset 2-bit counters, combinational read,
// synchronous read-modify-write with an override that forces weakly-taken.
module bp_counter_table
  import bp_pkg::*;
#(
  parameter int ENTRIES = 64,
  parameter int IDX     = $clog2(ENTRIES)
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [IDX-1:0] rd_idx,
  output bp_ctr_t        rd_ctr,
  input  logic           wr_en,
  input  logic [IDX-1:0] wr_idx,
  input  logic           wr_taken,
  input  logic           wr_force_wt
);

  bp_ctr_t ctr [ENTRIES];

  assign rd_ctr = ctr[rd_idx];

  // Train one counter per resolved branch; reset returns every entry to weakly-not-taken.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ctr[i] <= CTR_RESET;
      end
    end else if (wr_en) begin
      ctr[wr_idx] <= wr_force_wt ? WT : ctr_next(ctr[wr_idx], wr_taken);
    end
  end

endmodule

// File: rtl/branch_target_predictor.sv
// Gshare direction predictor with a direct-mapped tagged BTB. Lookup is
// combinational from pc; training happens on resolved branches from execute.
module branch_target_predictor
  import bp_pkg::*;
#(
  parameter int ENTRIES   = 64,
  parameter int HIST_BITS = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_mispredict,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
);

  localparam int IDX   = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX;
  localparam int HB_W  = (HIST_BITS > 0) ? HIST_BITS : 1;

  function automatic logic [31:0] sat_inc(logic [31:0] v);
    return (v == STAT_MAX) ? v : v + 32'd1;
  endfunction

  logic [ENTRIES-1:0] btb_valid;
  logic [TAG_W-1:0]   btb_tag    [ENTRIES];
  logic [31:0]        btb_target [ENTRIES];
  logic [HB_W-1:0]    ghr;

  logic [IDX-1:0]   idx, upd_idx, hist_ext, cidx, upd_cidx;
  logic [TAG_W-1:0] tag, upd_tag;
  logic             hit, upd_hit;
  bp_ctr_t          rd_ctr;

  assign idx     = pc[IDX+1:2];
  assign tag     = pc[31:IDX+2];
  assign upd_idx = upd_pc[IDX+1:2];
  assign upd_tag = upd_pc[31:IDX+2];

  // Zero-extend the history into the index width; empty when history is disabled.
  always_comb begin
    hist_ext = '0;
    for (int i = 0; i < HIST_BITS; i++) begin
      hist_ext[i] = ghr[i];
    end
  end

  assign cidx     = idx ^ hist_ext;
  assign upd_cidx = upd_idx ^ hist_ext;

  assign hit     = btb_valid[idx] && (btb_tag[idx] == tag);
  assign upd_hit = btb_valid[upd_idx] && (btb_tag[upd_idx] == upd_tag);

  assign pred_taken  = hit & rd_ctr[1];
  assign pred_target = pred_taken ? btb_target[idx] : pc + 32'd4;

  bp_counter_table #(
    .ENTRIES (ENTRIES),
    .IDX     (IDX)
  ) u_ctr (
    .clock       (clock),
    .reset       (reset),
    .rd_idx      (cidx),
    .rd_ctr      (rd_ctr),
    .wr_en       (upd_valid),
    .wr_idx      (upd_cidx),
    .wr_taken    (upd_taken),
    .wr_force_wt (upd_taken & ~upd_hit)
  );

  // Valid bits gate the untracked tag/target arrays, so only they need reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      btb_valid <= '0;
    end else if (upd_valid && upd_taken) begin
      btb_valid[upd_idx] <= 1'b1;
    end
  end

  // Taken branches (re)allocate their slot and always refresh the target.
  always_ff @(posedge clock) begin
    if (!reset && upd_valid && upd_taken) begin
      btb_tag[upd_idx]    <= upd_tag;
      btb_target[upd_idx] <= upd_target;
    end
  end

  generate
    if (HIST_BITS > 0) begin : g_ghr
      // Non-speculative history: shift in each resolved outcome.
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          ghr <= '0;
        end else if (upd_valid) begin
          ghr <= HB_W'({ghr, upd_taken});
        end
      end
    end else begin : g_no_ghr
      assign ghr = '0;
    end
  endgenerate

  // Saturating resolved-branch and mispredict counters.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else if (upd_valid) begin
      stat_branches <= sat_inc(stat_branches);
      if (upd_mispredict) begin
        stat_mispredicts <= sat_inc(stat_mispredicts);
      end
    end
  end

endmodule

// File: tb/tb_branch_target_predictor.sv
// Bench for branch_target_predictor: a bimodal (HIST_BITS=0) and a gshare
// (HIST_BITS=4) instance share stimulus; a behavioural model fills a
// scoreboard of expected lookups that is drained after each lookup settles.
module tb_branch_target_predictor;

  logic        clock;
  logic        reset;
  logic [31:0] pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_mispredict;

  logic        pt  [2];
  logic [31:0] ptg [2];
  logic [31:0] sb  [2];
  logic [31:0] sm  [2];

  branch_target_predictor #(.ENTRIES(64), .HIST_BITS(0)) dut0 (
    .clock(clock), .reset(reset), .pc(pc),
    .pred_taken(pt[0]), .pred_target(ptg[0]),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_mispredict(upd_mispredict),
    .stat_branches(sb[0]), .stat_mispredicts(sm[0])
  );

  branch_target_predictor #(.ENTRIES(64), .HIST_BITS(4)) dut4 (
    .clock(clock), .reset(reset), .pc(pc),
    .pred_taken(pt[1]), .pred_target(ptg[1]),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_mispredict(upd_mispredict),
    .stat_branches(sb[1]), .stat_mispredicts(sm[1])
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_vec  = 0;
  int n_miss = 0;

  // Behavioural model state, one copy per instance.
  logic        m_valid [2][64];
  logic [23:0] m_tag   [2][64];
  logic [31:0] m_tgt   [2][64];
  logic [1:0]  m_ctr   [2][64];
  logic [3:0]  m_ghr   [2];
  logic [3:0]  m_mask  [2];
  logic [31:0] m_br;
  logic [31:0] m_mp;

  typedef struct {
    int          d;
    logic [31:0] a;
    logic        t;
    logic [31:0] tg;
  } exp_t;
  exp_t exp_q[$];

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 64; i++) begin
        m_valid[d][i] = 1'b0;
        m_ctr[d][i]   = 2'b01;
      end
      m_ghr[d] = 4'd0;
    end
    m_br = 32'd0;
    m_mp = 32'd0;
  endtask

  task automatic model_predict(input int d, input logic [31:0] a,
                               output logic t, output logic [31:0] tg);
    logic [5:0] i, ci;
    logic       h;
    i  = a[7:2];
    ci = i ^ {2'b00, (m_ghr[d] & m_mask[d])};
    h  = m_valid[d][i] && (m_tag[d][i] == a[31:8]);
    t  = h && m_ctr[d][ci][1];
    tg = t ? m_tgt[d][i] : a + 32'd4;
  endtask

  task automatic model_update(input logic [31:0] a, input logic tk,
                              input logic [31:0] tgt, input logic mp);
    logic [5:0] i, ci;
    logic       h;
    for (int d = 0; d < 2; d++) begin
      i  = a[7:2];
      ci = i ^ {2'b00, (m_ghr[d] & m_mask[d])};
      h  = m_valid[d][i] && (m_tag[d][i] == a[31:8]);
      if (tk) begin
        if (h) begin
          m_ctr[d][ci] = (m_ctr[d][ci] == 2'b11) ? 2'b11 : m_ctr[d][ci] + 2'b01;
        end else begin
          m_valid[d][i] = 1'b1;
          m_tag[d][i]   = a[31:8];
          m_ctr[d][ci]  = 2'b10;
        end
        m_tgt[d][i] = tgt;
      end else begin
        m_ctr[d][ci] = (m_ctr[d][ci] == 2'b00) ? 2'b00 : m_ctr[d][ci] - 2'b01;
      end
      m_ghr[d] = {m_ghr[d][2:0], tk} & m_mask[d];
    end
    m_br = (m_br == 32'hFFFF_FFFF) ? m_br : m_br + 32'd1;
    if (mp) m_mp = (m_mp == 32'hFFFF_FFFF) ? m_mp : m_mp + 32'd1;
  endtask

  // Present a fetch PC, queue both instances' expected predictions, then
  // pop and compare once the combinational outputs have settled.
  task automatic lookup(input logic [31:0] a);
    exp_t e;
    pc = a;
    for (int d = 0; d < 2; d++) begin
      e.d = d;
      e.a = a;
      model_predict(d, a, e.t, e.tg);
      exp_q.push_back(e);
    end
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_vec++;
      if (pt[e.d] !== e.t || ptg[e.d] !== e.tg) begin
        n_miss++;
        $display("FAIL lookup dut%0d pc=%h: got taken=%b target=%h, want taken=%b target=%h",
                 e.d, e.a, pt[e.d], ptg[e.d], e.t, e.tg);
      end
    end
  endtask

  task automatic update(input logic [31:0] a, input logic tk,
                        input logic [31:0] tgt, input logic mp);
    upd_valid      = 1'b1;
    upd_pc         = a;
    upd_taken      = tk;
    upd_target     = tgt;
    upd_mispredict = mp;
    @(posedge clock);
    #1;
    model_update(a, tk, tgt, mp);
    upd_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    model_reset();
    lookup(32'h100);
    for (int d = 0; d < 2; d++) begin
      n_vec++;
      if (pt[d] !== 1'b0 || ptg[d] !== 32'h104) begin
        n_miss++;
        $display("FAIL reset_pred dut%0d: got %b/%h, want 0/00000104", d, pt[d], ptg[d]);
      end
      n_vec++;
      if (sb[d] !== 32'd0 || sm[d] !== 32'd0) begin
        n_miss++;
        $display("FAIL reset_stats dut%0d: got %0d/%0d, want 0/0", d, sb[d], sm[d]);
      end
    end
    #10;
    reset = 1'b0;
    lookup(32'h100);
  endtask

  task automatic test_train();
    update(32'h100, 1'b1, 32'h80, 1'b1);
    lookup(32'h100);
    n_vec++;
    if (pt[0] !== 1'b1 || ptg[0] !== 32'h80) begin
      n_miss++;
      $display("FAIL train_taken dut0: got %b/%h, want 1/00000080", pt[0], ptg[0]);
    end
    for (int d = 0; d < 2; d++) begin
      n_vec++;
      if (sb[d] !== 32'd1 || sm[d] !== 32'd1) begin
        n_miss++;
        $display("FAIL train_stats dut%0d: got %0d/%0d, want 1/1", d, sb[d], sm[d]);
      end
    end
    update(32'h100, 1'b0, 32'h0, 1'b0);
    update(32'h100, 1'b0, 32'h0, 1'b0);
    lookup(32'h100);
    n_vec++;
    if (pt[0] !== 1'b0 || ptg[0] !== 32'h104) begin
      n_miss++;
      $display("FAIL train_not_taken dut0: got %b/%h, want 0/00000104", pt[0], ptg[0]);
    end
  endtask

  task automatic test_saturate();
    for (int k = 0; k < 3; k++) update(32'h200, 1'b1, 32'h280, 1'b0);
    lookup(32'h200);
    update(32'h200, 1'b0, 32'h0, 1'b1);
    lookup(32'h200);
    n_vec++;
    if (pt[0] !== 1'b1 || ptg[0] !== 32'h280) begin
      n_miss++;
      $display("FAIL saturate dut0: got %b/%h, want 1/00000280", pt[0], ptg[0]);
    end
  endtask

  task automatic test_alias();
    update(32'h100, 1'b1, 32'h80, 1'b0);
    update(32'h1100, 1'b1, 32'h40, 1'b0);
    lookup(32'h100);
    n_vec++;
    if (pt[0] !== 1'b0 || ptg[0] !== 32'h104) begin
      n_miss++;
      $display("FAIL alias_evicted dut0: got %b/%h, want 0/00000104", pt[0], ptg[0]);
    end
    lookup(32'h1100);
    n_vec++;
    if (pt[0] !== 1'b1 || ptg[0] !== 32'h40) begin
      n_miss++;
      $display("FAIL alias_new dut0: got %b/%h, want 1/00000040", pt[0], ptg[0]);
    end
  endtask

  task automatic test_same_cycle();
    upd_valid      = 1'b1;
    upd_pc         = 32'h300;
    upd_taken      = 1'b1;
    upd_target     = 32'h380;
    upd_mispredict = 1'b1;
    lookup(32'h300);
    @(posedge clock);
    #1;
    model_update(32'h300, 1'b1, 32'h380, 1'b1);
    upd_valid = 1'b0;
    lookup(32'h300);
    n_vec++;
    if (pt[0] !== 1'b1 || ptg[0] !== 32'h380) begin
      n_miss++;
      $display("FAIL same_cycle_after dut0: got %b/%h, want 1/00000380", pt[0], ptg[0]);
    end
  endtask

  task automatic test_gshare();
    for (int k = 0; k < 32; k++) begin
      update(32'h400, (k % 2) == 0, 32'h480, 1'b0);
      lookup(32'h400);
    end
    for (int d = 0; d < 2; d++) begin
      n_vec++;
      if (sb[d] !== m_br || sm[d] !== m_mp) begin
        n_miss++;
        $display("FAIL gshare_stats dut%0d: got %0d/%0d, want %0d/%0d", d, sb[d], sm[d], m_br, m_mp);
      end
    end
  endtask

  task automatic test_reset_mid();
    update(32'h500, 1'b1, 32'h580, 1'b1);
    update(32'h504, 1'b1, 32'h5c0, 1'b0);
    lookup(32'h500);
    upd_valid      = 1'b1;
    upd_pc         = 32'h504;
    upd_taken      = 1'b1;
    upd_target     = 32'h600;
    upd_mispredict = 1'b1;
    #1;
    reset = 1'b1;
    model_reset();
    lookup(32'h500);
    lookup(32'h504);
    for (int d = 0; d < 2; d++) begin
      n_vec++;
      if (sb[d] !== 32'd0 || sm[d] !== 32'd0) begin
        n_miss++;
        $display("FAIL reset_mid_stats dut%0d: got %0d/%0d, want 0/0", d, sb[d], sm[d]);
      end
    end
    @(posedge clock);
    #1;
    upd_valid = 1'b0;
    reset     = 1'b0;
    lookup(32'h504);
    lookup(32'h400);
    for (int d = 0; d < 2; d++) begin
      n_vec++;
      if (sb[d] !== 32'd0 || sm[d] !== 32'd0) begin
        n_miss++;
        $display("FAIL reset_mid_after dut%0d: got %0d/%0d, want 0/0", d, sb[d], sm[d]);
      end
    end
    update(32'h504, 1'b1, 32'h5c0, 1'b0);
    lookup(32'h504);
  endtask

  initial begin
    m_mask[0]      = 4'h0;
    m_mask[1]      = 4'hF;
    reset          = 1'b1;
    pc             = 32'h0;
    upd_valid      = 1'b0;
    upd_pc         = 32'h0;
    upd_taken      = 1'b0;
    upd_target     = 32'h0;
    upd_mispredict = 1'b0;
    test_reset();
    @(posedge clock);
    #1;
    test_train();
    test_saturate();
    test_alias();
    test_same_cycle();
    test_gshare();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/branch_target_predictor.md
# branch_target_predictor

Fetch-side branch predictor for the five-stage RISC-V pipeline: gives the fetch stage a same-cycle taken/not-taken prediction and target for the current PC. It is trained by branches resolved in the execute stage. Direction comes from a gshare-indexed table of 2-bit saturating counters; targets come from a direct-mapped, tagged branch target buffer (BTB). Two statistics counters give verification and performance visibility.

## Interface
- ENTRIES, 64: BTB and counter-table depth; power of two, 4..1024; IDX = log2(ENTRIES)
- HIST_BITS, 4: global history length, 0..IDX; 0 = pure bimodal
- clock  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-high
- pc  in  32  current fetch PC
- pred_taken  out  1  predict taken for pc
- pred_target  out  32  predicted next PC
- upd_valid  in  1  a branch resolved in execute this cycle
- upd_pc  in  32  PC of resolved branch
- upd_taken  in  1  actual outcome
- upd_target  in  32  actual taken target
- upd_mispredict  in  1  execute flagged a mispredict for this branch
- stat_branches  out  32  resolved-branch count
- stat_mispredicts  out  32  mispredict count

## Operation
- Fields: index = pc[IDX+1:2]; tag = pc[31:IDX+2]; pc[1:0] ignored.
- Counter index = index XOR {zero-extend, ghr[HIST_BITS-1:0]}. BTB index = index with no history.
- Lookup is combinational.
  - hit = btb_valid[index] & (btb_tag[index] == tag).
  - pred_taken = hit & ctr[cidx][1].
  - pred_target = pred_taken ? btb_target[index] : pc + 4, mod 2^32.
- Counter states: SNT=00, WNT=01, WT=10, ST=11.
- Update on the clock edge when upd_valid = 1. All fields are computed from upd_pc and the ghr value before this update.
  - upd_taken = 1 with BTB hit: counter increments, saturating at ST; btb_target is overwritten with upd_target.
  - upd_taken = 1 with BTB miss (invalid or tag mismatch): valid, tag and target are written; counter is forced to WT.
  - upd_taken = 0: counter decrements, saturating at SNT; BTB is unchanged.
  - ghr <= {ghr[HIST_BITS-2:0], upd_taken}. No ghr exists when HIST_BITS = 0.
  - stat_branches increments; stat_mispredicts increments if upd_mispredict = 1. Both saturate at 32'hFFFF_FFFF.
- History is non-speculative: it advances only on resolved branches. No recovery logic.
- When upd_valid = 0, no state changes.

## Timing
- Lookup latency: 0 cycles, combinational from pc.
- Update: written at the edge where upd_valid is sampled high. Visible to lookup from the next cycle.
- Same-cycle lookup and update to the same entry: lookup returns the pre-update value.
- Reset (asynchronous, any time, including mid-update):
  - all btb_valid = 0, all counters = WNT, ghr = 0, both stats = 0.
  - Outputs during and after reset: pred_taken = 0, pred_target = pc + 4.
  - An update in flight when reset asserts is discarded.
- Target arrays (btb_tag, btb_target) need no reset; they are gated by valid.
- Storage is flops, sized for ENTRIES ≤ 1024. Reset of the counter table must be asynchronous.

## Structure
- Package bp_pkg holds:
  - typedef enum logic [1:0] bp_ctr_t {SNT, WNT, WT, ST}
  - function ctr_next(bp_ctr_t c, logic taken), saturating
  - localparam CTR_RESET = WNT
  - localparam STAT_MAX = 32'hFFFF_FFFF
- One sub-module, bp_counter_table: ENTRIES × 2-bit counters with async reset, combinational read port, and a synchronous read-modify-write port that takes a force-WT flag.
- BTB arrays, ghr, index hashing and stats live in the top.

## Test plan
- Reset, then pc = 0x100 → pred_taken = 0, pred_target = 0x104. Both stats read 0.
- HIST_BITS = 0. Update 0x100 taken, target 0x80, mispredict = 1. Next cycle pc = 0x100 → pred_taken = 1, pred_target = 0x80, stat_mispredicts = 1. Two not-taken updates → pred_taken = 0 (WT→WNT→SNT).
- Three taken updates on 0x200 → counter ST. One not-taken → still predicts taken (WT).
- Aliasing, ENTRIES = 64. 0x100 taken → 0x80. Then 0x1100 (same index, new tag) taken → 0x40. Lookup 0x100 → miss, pred_taken = 0. Lookup 0x1100 → 0x40.
- Same-cycle conflict: pc = 0x300 and update 0x300 taken on the first training edge → pred_taken = 0 that cycle, 1 the next.
- Gshare, HIST_BITS = 4. Alternate taken/not-taken on 0x400 for 32 updates, then lookups track the alternation. Assert reset mid-sequence → all lookups miss and stats read 0 immediately.
